// File: rtl/lcd_bus_monitor.sv
// Passive monitor for the HD44780-style LCD write bus. Keeps a 32-cell shadow
// of the display RAM plus cursor, entry-mode and display-on state for debug.
module lcd_bus_monitor #(
  parameter logic [7:0] CLEAR_CHAR = 8'h20,
  parameter int         CNT_WIDTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 lcd_en,
  input  logic                 lcd_rs,
  input  logic                 lcd_rw,
  input  logic [7:0]           lcd_data,
  input  logic [4:0]           rd_addr,
  output logic [7:0]           rd_data,
  output logic [4:0]           cursor_addr,
  output logic                 increment,
  output logic                 display_on,
  output logic                 busy,
  output logic                 overrun,
  output logic                 cmd_valid,
  output logic [CNT_WIDTH-1:0] write_count
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t     state, state_nx;
  logic       en_q, rs_q, rw_q, en_prev;
  logic [7:0] data_q;
  logic       hold_rs, hold_rw;
  logic [7:0] hold_data;
  logic [4:0] sweep_idx, sweep_nx, cursor_nx;
  logic       inc_nx, disp_nx, ovr_nx, cv_nx, cnt_inc;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       fall;
  logic [7:0] shadow [32];

  assign fall = en_prev & ~en_q;
  assign busy = (state == CLEAR);

  // Pin capture; hold regs keep the last values seen while EN was high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_q      <= 1'b0;
      rs_q      <= 1'b0;
      rw_q      <= 1'b0;
      data_q    <= 8'h00;
      en_prev   <= 1'b0;
      hold_rs   <= 1'b0;
      hold_rw   <= 1'b0;
      hold_data <= 8'h00;
    end else begin
      en_q    <= lcd_en;
      rs_q    <= lcd_rs;
      rw_q    <= lcd_rw;
      data_q  <= lcd_data;
      en_prev <= en_q;
      if (en_q) begin
        hold_rs   <= rs_q;
        hold_rw   <= rw_q;
        hold_data <= data_q;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    sweep_nx  = sweep_idx;
    cursor_nx = cursor_addr;
    inc_nx    = increment;
    disp_nx   = display_on;
    ovr_nx    = overrun;
    cv_nx     = 1'b0;
    cnt_inc   = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = cursor_addr;
    wr_data   = hold_data;
    case (state)
      CLEAR: begin
        wr_en    = 1'b1;
        wr_addr  = sweep_idx;
        wr_data  = CLEAR_CHAR;
        sweep_nx = sweep_idx + 5'd1;
        if (sweep_idx == 5'd31) state_nx = IDLE;
        if (fall) ovr_nx = 1'b1;
      end
      default: begin
        if (fall && !hold_rw) begin
          if (hold_rs) begin
            wr_en     = 1'b1;
            cursor_nx = cursor_addr + (increment ? 5'd1 : 5'd31);
            cnt_inc   = 1'b1;
            cv_nx     = 1'b1;
          end else begin
            cv_nx = (hold_data != 8'h00);
            casez (hold_data)
              8'b1???_????: cursor_nx = {hold_data[6], hold_data[3:0]};
              8'b0000_1???: disp_nx = hold_data[2];
              8'b0000_01??: inc_nx = hold_data[1];
              8'b0000_001?: cursor_nx = 5'd0;
              8'b0000_0001: begin
                state_nx  = CLEAR;
                sweep_nx  = 5'd0;
                cursor_nx = 5'd0;
                inc_nx    = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= CLEAR;
      sweep_idx   <= 5'd0;
      cursor_addr <= 5'd0;
      increment   <= 1'b1;
      display_on  <= 1'b0;
      overrun     <= 1'b0;
      cmd_valid   <= 1'b0;
      write_count <= '0;
      rd_data     <= 8'h00;
    end else begin
      state       <= state_nx;
      sweep_idx   <= sweep_nx;
      cursor_addr <= cursor_nx;
      increment   <= inc_nx;
      display_on  <= disp_nx;
      overrun     <= ovr_nx;
      cmd_valid   <= cv_nx;
      if (cnt_inc && write_count != {CNT_WIDTH{1'b1}})
        write_count <= write_count + 1'b1;
      rd_data     <= shadow[rd_addr];
    end
  end

  // Shadow RAM has no reset; the clear sweep initialises it.
  always_ff @(posedge clock) begin
    if (wr_en) shadow[wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Randomised and directed bench for lcd_bus_monitor against a
// transaction-level model of the display state.
`timescale 1ns/1ps
module tb_lcd_bus_monitor;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          lcd_en = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
  logic [7:0]    lcd_data = 8'h00;
  logic [4:0]    rd_addr = 5'd0;
  logic [7:0]    rd_data;
  logic [4:0]    cursor_addr;
  logic          increment, display_on, busy, overrun, cmd_valid;
  logic [CW-1:0] write_count;

  lcd_bus_monitor #(.CLEAR_CHAR(8'h20), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .lcd_en(lcd_en), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_data(lcd_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .cursor_addr(cursor_addr), .increment(increment),
    .display_on(display_on), .busy(busy), .overrun(overrun),
    .cmd_valid(cmd_valid), .write_count(write_count)
  );

  always #10 clock = ~clock;

  int n_chk = 0, n_fail = 0;
  int busy_cnt = 0, cv_cnt = 0;

  always @(negedge clock) begin
    if (busy) busy_cnt++;
    if (cmd_valid) cv_cnt++;
  end

  // Model of what the panel has been told
  logic [7:0] m_mem [32];
  int         m_cur, m_cnt, m_cv;
  bit         m_inc, m_disp, m_ovr;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
    m_cur = 0; m_inc = 1; m_disp = 0; m_cnt = 0; m_ovr = 0;
  endtask

  task automatic model_op(input bit rs, input bit rw, input logic [7:0] d);
    if (rw) return;
    if (rs) begin
      m_mem[m_cur] = d;
      m_cur = (m_cur + (m_inc ? 1 : 31)) % 32;
      if (m_cnt < CMAX) m_cnt++;
      m_cv++;
      return;
    end
    if (d == 0) return;
    m_cv++;
    if (d >= 128) m_cur = (d[6] ? 16 : 0) + (d % 16);
    else if (d >= 16) begin end
    else if (d >= 8) m_disp = d[2];
    else if (d >= 4) m_inc = d[1];
    else if (d >= 2) m_cur = 0;
    else begin
      for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
      m_cur = 0; m_inc = 1;
    end
  endtask

  task automatic bus(input bit rs, input bit rw, input logic [7:0] d, input int hi);
    @(posedge clock); #1;
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1'b1;
    repeat (hi) @(posedge clock);
    #1 lcd_en = 1'b0;
    lcd_data = 8'($urandom); lcd_rs = 1'($urandom); lcd_rw = 1'($urandom);
    repeat (3) @(posedge clock);
  endtask

  task automatic op(input bit rs, input bit rw, input logic [7:0] d, input int hi);
    bus(rs, rw, d, hi);
    model_op(rs, rw, d);
  endtask

  task automatic read_cell(input int a, output logic [7:0] d);
    @(negedge clock) rd_addr = 5'(a);
    @(posedge clock);
    @(negedge clock) d = rd_data;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_chk++;
    if ({busy, cursor_addr, increment, display_on, overrun, cmd_valid, write_count, rd_data} !==
        {1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b cur=%0d inc=%b disp=%b ovr=%b cv=%b wc=%0d rd=%h", busy,
               cursor_addr, increment, display_on, overrun, cmd_valid, write_count, rd_data);
    end
    reset = 1'b0;
    repeat (31) @(posedge clock);
    @(negedge clock);
    n_chk++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_cycle31: got %b want 1", busy); end
    @(posedge clock); @(negedge clock);
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_cycle32: got %b want 0", busy); end
    model_reset();
    for (int i = 0; i < 32; i++) begin
      read_cell(i, d);
      n_chk++;
      if (d !== m_mem[i]) begin n_fail++; $display("FAIL reset_cell[%0d]: got %h want %h", i, d, m_mem[i]); end
    end
  endtask

  task automatic test_data_write();
    int cv0 = cv_cnt;
    logic [7:0] d;
    @(posedge clock); #1;
    lcd_rs = 1; lcd_rw = 0; lcd_data = 8'h41; lcd_en = 1;
    repeat (4) @(posedge clock);
    #1 lcd_en = 0; lcd_data = 8'hFF;
    @(negedge clock);
    @(negedge clock);
    n_chk++;
    if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL cv_early: got %b want 0", cmd_valid); end
    @(negedge clock);
    n_chk++;
    if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL cv_pulse: got %b want 1", cmd_valid); end
    @(negedge clock);
    n_chk++;
    if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL cv_width: got %b want 0", cmd_valid); end
    model_op(1, 0, 8'h41);
    op(1, 0, 8'h42, 4);
    n_chk++;
    if (cursor_addr !== 5'd2 || write_count !== 4'd2 || cv_cnt - cv0 != 2) begin
      n_fail++;
      $display("FAIL data_write: cur=%0d wc=%0d cv=%0d want 2 2 2", cursor_addr, write_count, cv_cnt - cv0);
    end
    read_cell(0, d);
    n_chk++;
    if (d !== 8'h41) begin n_fail++; $display("FAIL cell0: got %h want 41", d); end
    read_cell(1, d);
    n_chk++;
    if (d !== 8'h42) begin n_fail++; $display("FAIL cell1: got %h want 42", d); end
  endtask

  task automatic test_cursor_wrap();
    logic [7:0] d;
    op(0, 0, 8'hCF, 2);
    n_chk++;
    if (cursor_addr !== 5'd31) begin n_fail++; $display("FAIL set_ddram_cf: got %0d want 31", cursor_addr); end
    op(1, 0, 8'h5A, 1);
    op(1, 0, 8'h5B, 3);
    read_cell(31, d);
    n_chk++;
    if (d !== 8'h5A) begin n_fail++; $display("FAIL wrap_cell31: got %h want 5a", d); end
    read_cell(0, d);
    n_chk++;
    if (d !== 8'h5B) begin n_fail++; $display("FAIL wrap_cell0: got %h want 5b", d); end
    n_chk++;
    if (cursor_addr !== 5'd1) begin n_fail++; $display("FAIL wrap_cursor: got %0d want 1", cursor_addr); end
  endtask

  task automatic test_decrement();
    logic [7:0] d;
    op(0, 0, 8'h04, 2);
    op(0, 0, 8'hD0, 2);
    n_chk++;
    if (cursor_addr !== 5'd16 || increment !== 1'b0) begin
      n_fail++; $display("FAIL dec_setup: cur=%0d inc=%b want 16 0", cursor_addr, increment);
    end
    op(1, 0, 8'h31, 2);
    op(1, 0, 8'h32, 2);
    read_cell(16, d);
    n_chk++;
    if (d !== 8'h31) begin n_fail++; $display("FAIL dec_cell16: got %h want 31", d); end
    read_cell(15, d);
    n_chk++;
    if (d !== 8'h32) begin n_fail++; $display("FAIL dec_cell15: got %h want 32", d); end
    n_chk++;
    if (cursor_addr !== 5'd14) begin n_fail++; $display("FAIL dec_cursor: got %0d want 14", cursor_addr); end
  endtask

  task automatic test_clear_overrun();
    int b0, wc0, bound;
    logic [7:0] d;
    op(0, 0, 8'h0C, 2);
    n_chk++;
    if (display_on !== 1'b1) begin n_fail++; $display("FAIL display_on: got %b want 1", display_on); end
    wc0 = m_cnt;
    b0 = busy_cnt;
    op(0, 0, 8'h01, 4);
    repeat (2) @(posedge clock);
    bus(1, 0, 8'h77, 4);
    m_ovr = 1;
    bound = 0;
    while (busy && bound < 100) begin @(posedge clock); bound++; end
    @(negedge clock);
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_timeout: busy still %b", busy); end
    n_chk++;
    if (busy_cnt - b0 != 32) begin n_fail++; $display("FAIL clear_busy_len: got %0d want 32", busy_cnt - b0); end
    n_chk++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun: got %b want 1", overrun); end
    n_chk++;
    if (write_count !== CW'(wc0) || cursor_addr !== 5'd0 || increment !== 1'b1 || display_on !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_state: wc=%0d cur=%0d inc=%b disp=%b want %0d 0 1 1", write_count, cursor_addr,
               increment, display_on, wc0);
    end
    for (int i = 0; i < 32; i++) begin
      read_cell(i, d);
      n_chk++;
      if (d !== m_mem[i]) begin n_fail++; $display("FAIL clear_cell[%0d]: got %h want %h", i, d, m_mem[i]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] d, r;
    bit rs, rw;
    int k, cv0;
    cv0 = cv_cnt - m_cv;
    for (int n = 0; n < 60; n++) begin
      r = 8'($urandom);
      k = $urandom_range(0, 7);
      rs = 0; rw = 0;
      case (k)
        0, 1, 2: begin rs = 1; d = r; end
        3: begin rs = r[7]; rw = 1; d = 8'($urandom); end
        4: d = {1'b1, r[6:0]};
        5: d = {5'b00001, r[2:0]};
        6: d = {6'b000001, r[1:0]};
        default: case (r[7:6])
          2'd0: d = {7'b0000001, r[0]};
          2'd1: d = {3'b001, r[4:0]};
          default: d = 8'h00;
        endcase
      endcase
      op(rs, rw, d, $urandom_range(1, 5));
      @(negedge clock);
      n_chk++;
      if (cursor_addr !== 5'(m_cur) || increment !== m_inc || display_on !== m_disp) begin
        n_fail++;
        $display("FAIL rand_ctrl[%0d] op=%b%b %h: cur=%0d inc=%b disp=%b want %0d %b %b", n, rs, rw, d,
                 cursor_addr, increment, display_on, m_cur, m_inc, m_disp);
      end
      n_chk++;
      if (write_count !== CW'(m_cnt)) begin
        n_fail++; $display("FAIL rand_count[%0d]: got %0d want %0d", n, write_count, m_cnt);
      end
      n_chk++;
      if (cv_cnt - cv0 != m_cv) begin
        n_fail++; $display("FAIL rand_cmd_valid[%0d]: got %0d want %0d", n, cv_cnt - cv0, m_cv);
      end
    end
    for (int i = 0; i < 32; i++) begin
      read_cell(i, d);
      n_chk++;
      if (d !== m_mem[i]) begin n_fail++; $display("FAIL rand_cell[%0d]: got %h want %h", i, d, m_mem[i]); end
    end
    n_chk++;
    if (overrun !== m_ovr) begin n_fail++; $display("FAIL overrun_sticky: got %b want %b", overrun, m_ovr); end
  endtask

  task automatic test_read_abort();
    int cv0, cur0, n;
    logic [7:0] d;
    cv0 = cv_cnt;
    cur0 = m_cur;
    op(0, 1, 8'h41, 3);
    op(1, 1, 8'h55, 2);
    @(negedge clock);
    n_chk++;
    if (cv_cnt != cv0 || cursor_addr !== 5'(cur0)) begin
      n_fail++; $display("FAIL read_ignored: cv+%0d cur=%0d want +0 %0d", cv_cnt - cv0, cursor_addr, cur0);
    end
    read_cell(cur0, d);
    n_chk++;
    if (d !== m_mem[cur0]) begin n_fail++; $display("FAIL read_cell: got %h want %h", d, m_mem[cur0]); end
    bus(0, 0, 8'h01, 2);
    repeat (9) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    n_chk++;
    if ({busy, cursor_addr, display_on, overrun, cmd_valid, write_count} !==
        {1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL midsweep_reset: busy=%b cur=%0d disp=%b ovr=%b cv=%b wc=%0d", busy, cursor_addr,
               display_on, overrun, cmd_valid, write_count);
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    #2 reset = 1'b0;
    model_reset();
    n = 0;
    while (busy && n < 100) begin @(posedge clock); #1; n++; end
    n_chk++;
    if (n != 32) begin n_fail++; $display("FAIL restart_busy_len: got %0d want 32", n); end
    for (int i = 0; i < 32; i++) begin
      read_cell(i, d);
      n_chk++;
      if (d !== m_mem[i]) begin n_fail++; $display("FAIL restart_cell[%0d]: got %h want %h", i, d, m_mem[i]); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_cv = 0;
    model_reset();
    test_reset();
    test_data_write();
    test_cursor_wrap();
    test_decrement();
    test_clear_overrun();
    test_random();
    test_read_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
